// File: rtl/cycle_sequencer_pkg.sv
// Shared control-unit constants: one-hot T-state and M-cycle codes, sequencer state enum.
package cycle_sequencer_pkg;

    localparam logic [3:0] STEP_T1 = 4'b0001;
    localparam logic [3:0] STEP_T2 = 4'b0010;
    localparam logic [3:0] STEP_T3 = 4'b0100;
    localparam logic [3:0] STEP_T4 = 4'b1000;

    localparam logic [7:0] MCYCLE_M1   = 8'h01;
    localparam logic [7:0] MCYCLE_NONE = 8'h00;

    typedef enum logic [0:0] {
        SEQ_RUN  = 1'b0,
        SEQ_HALT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/cycle_sequencer_onehot_ring.sv
// One-hot rotate register with clear > load-first-bit > rotate priority; resets to bit 0 set.
// Single-cycle update, holds when no control is active.
module onehot_ring #(
    parameter int WIDTH = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_En,
    input  logic             i_Load,
    input  logic             i_Clear,
    output logic [WIDTH-1:0] o_Ring
);

    localparam logic [WIDTH-1:0] FIRST = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_ring;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_ring <= FIRST;
        end else if (i_Clear) begin
            r_ring <= '0;
        end else if (i_Load) begin
            r_ring <= FIRST;
        end else if (i_En) begin
            r_ring <= {r_ring[WIDTH-2:0], r_ring[WIDTH-1]};
        end
    end

    assign o_Ring = r_ring;

endmodule

// File: rtl/cycle_sequencer.sv
// T-state / M-cycle sequencer with bus-wait stall, HALT/wake and optional overrun fault.
// Build option: define CYCLE_SEQ_FAULT_EN to include the sticky overrun fault register.
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter int STEPS   = 4,
    parameter int MCYCLES = 8
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Clk_En,
    input  logic               i_IR_Fetch,
    input  logic               i_Stall,
    input  logic               i_Halt,
    input  logic               i_Wake,
    output logic [STEPS-1:0]   o_Cycle_Step,
    output logic [MCYCLES-1:0] o_Cycle_Count,
    output logic               o_IR_Latch,
    output logic               o_Halted,
    output logic               o_Fault
);

    seq_state_e         r_state;
    logic               r_ir_latch;
    logic               r_halted;
    logic [STEPS-1:0]   w_step;
    logic [MCYCLES-1:0] w_count;
    logic               w_adv;
    logic               w_bnd;
    logic               w_cnt_en;
    logic               w_cnt_load;
    logic               w_cnt_clear;

    assign w_adv = i_Clk_En & ~i_Stall;
    assign w_bnd = w_adv & w_step[STEPS-1];

    // Overrun at M8 needs no special case: rotating the count wraps it back to M1.
    always_comb begin
        w_cnt_en    = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_clear = 1'b0;
        if (w_bnd) begin
            if (r_state == SEQ_RUN) begin
                if (i_IR_Fetch) begin
                    w_cnt_clear = i_Halt;
                    w_cnt_load  = ~i_Halt;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end else begin
                w_cnt_load = i_Wake;
            end
        end
    end

    onehot_ring #(.WIDTH(STEPS)) u_step_ring (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_En    (w_adv),
        .i_Load  (1'b0),
        .i_Clear (1'b0),
        .o_Ring  (w_step)
    );

    onehot_ring #(.WIDTH(MCYCLES)) u_count_ring (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_En    (w_cnt_en),
        .i_Load  (w_cnt_load),
        .i_Clear (w_cnt_clear),
        .o_Ring  (w_count)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state    <= SEQ_RUN;
            r_ir_latch <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_ir_latch <= 1'b0;
            if (w_bnd) begin
                case (r_state)
                    SEQ_RUN: begin
                        if (i_IR_Fetch && i_Halt) begin
                            r_state  <= SEQ_HALT;
                            r_halted <= 1'b1;
                        end else if (i_IR_Fetch) begin
                            r_ir_latch <= 1'b1;
                        end
                    end
                    SEQ_HALT: begin
                        if (i_Wake) begin
                            r_state    <= SEQ_RUN;
                            r_halted   <= 1'b0;
                            r_ir_latch <= 1'b1;
                        end
                    end
                    default: r_state <= SEQ_RUN;
                endcase
            end
        end
    end

`ifdef CYCLE_SEQ_FAULT_EN
    logic r_fault;
    logic w_overrun;

    assign w_overrun = w_bnd & (r_state == SEQ_RUN) & ~i_IR_Fetch & w_count[MCYCLES-1];

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_fault <= 1'b0;
        end else if (w_overrun) begin
            r_fault <= 1'b1;
        end
    end

    assign o_Fault = r_fault;

`ifndef SYNTHESIS
    overrun_seen: cover property (@(posedge i_Clk) disable iff (!i_Rst_n) w_overrun);
`endif
`else
    assign o_Fault = 1'b0;
`endif

    assign o_Cycle_Step  = w_step;
    assign o_Cycle_Count = w_count;
    assign o_IR_Latch    = r_ir_latch;
    assign o_Halted      = r_halted;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Bench for cycle_sequencer: abstract T/M index model checked every cycle plus directed literal checks.
module tb_cycle_sequencer;

    localparam bit FAULT_EN =
`ifdef CYCLE_SEQ_FAULT_EN
        1'b1;
`else
        1'b0;
`endif

    logic       i_Clk = 1'b0;
    logic       i_Rst_n = 1'b0;
    logic       i_Clk_En = 1'b0;
    logic       i_IR_Fetch = 1'b0;
    logic       i_Stall = 1'b0;
    logic       i_Halt = 1'b0;
    logic       i_Wake = 1'b0;
    logic [3:0] o_Cycle_Step;
    logic [7:0] o_Cycle_Count;
    logic       o_IR_Latch;
    logic       o_Halted;
    logic       o_Fault;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    cycle_sequencer #(.STEPS(4), .MCYCLES(8)) dut (
        .i_Clk         (i_Clk),
        .i_Rst_n       (i_Rst_n),
        .i_Clk_En      (i_Clk_En),
        .i_IR_Fetch    (i_IR_Fetch),
        .i_Stall       (i_Stall),
        .i_Halt        (i_Halt),
        .i_Wake        (i_Wake),
        .o_Cycle_Step  (o_Cycle_Step),
        .o_Cycle_Count (o_Cycle_Count),
        .o_IR_Latch    (o_IR_Latch),
        .o_Halted      (o_Halted),
        .o_Fault       (o_Fault)
    );

    always #5 i_Clk = ~i_Clk;

    // Model: T-state index 0..3, M-cycle index 0..7, plus halted/latch/fault flags.
    int m_t = 0;
    int m_m = 0;
    bit m_halt = 0, m_latch = 0, m_fault = 0;

    always @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            m_t = 0; m_m = 0; m_halt = 0; m_latch = 0; m_fault = 0;
        end else begin
            m_latch = 0;
            if (i_Clk_En && !i_Stall) begin
                if (m_t == 3) begin
                    if (m_halt) begin
                        if (i_Wake) begin
                            m_halt = 0; m_m = 0; m_latch = 1;
                        end
                    end else if (i_IR_Fetch) begin
                        m_m = 0;
                        if (i_Halt) m_halt = 1;
                        else m_latch = 1;
                    end else if (m_m == 7) begin
                        m_m = 0;
                        if (FAULT_EN) m_fault = 1;
                    end else begin
                        m_m = m_m + 1;
                    end
                end
                m_t = (m_t + 1) % 4;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_Clk) begin
        if (cmp_on && i_Rst_n) begin
            check("model_step", 32'(o_Cycle_Step), 32'(4'(1) << m_t));
            check("model_count", 32'(o_Cycle_Count), m_halt ? 32'h0 : 32'(8'(1) << m_m));
            check("model_latch", 32'(o_IR_Latch), 32'(m_latch));
            check("model_halted", 32'(o_Halted), 32'(m_halt));
            check("model_fault", 32'(o_Fault), 32'(m_fault));
        end
    end

    task automatic tick(input logic en, input logic stall, input logic fetch,
                        input logic halt, input logic wake);
        i_Clk_En = en; i_Stall = stall; i_IR_Fetch = fetch; i_Halt = halt; i_Wake = wake;
        @(posedge i_Clk);
        @(negedge i_Clk);
        #1;
    endtask

    int npulse;
    logic [3:0] exp_step_tbl [8];

    initial begin
        repeat (2) @(negedge i_Clk);
        #1;
        check("rst_step", 32'(o_Cycle_Step), 32'h1);
        check("rst_count", 32'(o_Cycle_Count), 32'h01);
        check("rst_latch", 32'(o_IR_Latch), 32'h0);
        check("rst_halted", 32'(o_Halted), 32'h0);
        check("rst_fault", 32'(o_Fault), 32'h0);
        i_Rst_n = 1'b1;
        cmp_on = 1'b1;

        // Three-M-cycle instruction: fetch asserted during M3 only.
        npulse = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1, 0, (i >= 9), 0, 0);
            npulse += int'(o_IR_Latch);
            if (i == 4) check("t1_count_m2", 32'(o_Cycle_Count), 32'h02);
            if (i == 8) check("t1_count_m3", 32'(o_Cycle_Count), 32'h04);
        end
        check("t1_count_m1", 32'(o_Cycle_Count), 32'h01);
        check("t1_latch", 32'(o_IR_Latch), 32'h1);
        check("t1_npulse", 32'(npulse), 32'h1);
        check("t1_step", 32'(o_Cycle_Step), 32'h1);

        // Stall with every other input active must freeze everything.
        tick(1, 0, 0, 0, 0);
        check("t2_step_pre", 32'(o_Cycle_Step), 32'h2);
        check("t2_latch_clr", 32'(o_IR_Latch), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick(1, 1, 1, 1, 1);
            check("t2_stall_step", 32'(o_Cycle_Step), 32'h2);
            check("t2_stall_count", 32'(o_Cycle_Count), 32'h01);
            check("t2_stall_latch", 32'(o_IR_Latch), 32'h0);
        end
        tick(1, 0, 0, 0, 0);
        check("t2_step_post", 32'(o_Cycle_Step), 32'h4);

        // HALT entry, off-boundary wake ignored, wake at next boundary.
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 1, 1, 0);
        check("t3_halt_count", 32'(o_Cycle_Count), 32'h00);
        check("t3_halted", 32'(o_Halted), 32'h1);
        check("t3_halt_latch", 32'(o_IR_Latch), 32'h0);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        check("t3_step_t3", 32'(o_Cycle_Step), 32'h4);
        tick(1, 0, 0, 0, 1);
        check("t3_offbnd_halted", 32'(o_Halted), 32'h1);
        check("t3_offbnd_count", 32'(o_Cycle_Count), 32'h00);
        tick(1, 0, 0, 0, 1);
        check("t3_wake_count", 32'(o_Cycle_Count), 32'h01);
        check("t3_wake_halted", 32'(o_Halted), 32'h0);
        check("t3_wake_latch", 32'(o_IR_Latch), 32'h1);

        // Overrun: halt without fetch is ignored; count walks to M8 then wraps.
        for (int i = 1; i <= 32; i++) begin
            tick(1, 0, 0, 1, 0);
            if (i == 4) begin
                check("t4_count_m2", 32'(o_Cycle_Count), 32'h02);
                check("t4_not_halted", 32'(o_Halted), 32'h0);
            end
            if (i == 28) begin
                check("t4_count_m8", 32'(o_Cycle_Count), 32'h80);
                check("t4_fault_pre", 32'(o_Fault), 32'h0);
            end
        end
        check("t4_count_wrap", 32'(o_Cycle_Count), 32'h01);
        check("t4_fault", 32'(o_Fault), 32'(FAULT_EN));

        // Half-rate enable: each T-state lasts two clocks.
        exp_step_tbl = '{4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h1};
        for (int i = 0; i < 8; i++) begin
            tick((i % 2) == 0, 0, 0, 0, 0);
            check("t5_step", 32'(o_Cycle_Step), 32'(exp_step_tbl[i]));
        end
        check("t5_count", 32'(o_Cycle_Count), 32'h02);

        // Asynchronous reset mid-M-cycle.
        for (int i = 0; i < 6; i++) tick(1, 0, 0, 0, 0);
        check("t6_pre_count", 32'(o_Cycle_Count), 32'h04);
        check("t6_pre_step", 32'(o_Cycle_Step), 32'h4);
        i_Rst_n = 1'b0;
        #1;
        check("t6_rst_step", 32'(o_Cycle_Step), 32'h1);
        check("t6_rst_count", 32'(o_Cycle_Count), 32'h01);
        check("t6_rst_latch", 32'(o_IR_Latch), 32'h0);
        check("t6_rst_halted", 32'(o_Halted), 32'h0);
        check("t6_rst_fault", 32'(o_Fault), 32'h0);
        #1;
        i_Rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0);
        check("t6_post3_step", 32'(o_Cycle_Step), 32'h8);
        check("t6_post3_count", 32'(o_Cycle_Count), 32'h01);
        tick(1, 0, 0, 0, 0);
        check("t6_post4_count", 32'(o_Cycle_Count), 32'h02);
        check("t6_post4_step", 32'(o_Cycle_Step), 32'h1);

        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

Generates the one-hot T-state (`o_Cycle_Step`) and M-cycle (`o_Cycle_Count`) vectors consumed by every per-instruction microcode block in the control unit.
- Sits directly upstream of the microcode decoders and closes the loop with their OR-combined `IR_Fetch` output, restarting the M-cycle count at each instruction boundary.
- Also implements bus-wait stalls, HALT entry and wake, and overrun detection.

## Interface
Parameters:
- STEPS, 4, T-states per M-cycle (width of `o_Cycle_Step`)
- MCYCLES, 8, maximum M-cycles per instruction (width of `o_Cycle_Count`)

Ports:
- i_Clk  in  1  system clock; all state changes on rising edge
- i_Rst_n  in  1  asynchronous, active-low reset
- i_Clk_En  in  1  T-state tick; state advances only when high
- i_IR_Fetch  in  1  OR of all microcode `o_IR_Fetch`; current M-cycle is the instruction's last
- i_Stall  in  1  bus wait; freezes step and count
- i_Halt  in  1  HALT decoded in current instruction
- i_Wake  in  1  pending enabled interrupt (level)
- o_Cycle_Step  out  STEPS  one-hot T-state
- o_Cycle_Count  out  MCYCLES  one-hot M-cycle; all-zero while halted
- o_IR_Latch  out  1  one-clock pulse: latch opcode into IR
- o_Halted  out  1  HALT state
- o_Fault  out  1  sticky overrun flag

## Operation
- States: RUN, HALT.
- Reset values: Step = 0001, Count = 0x01, RUN, o_IR_Latch = 0, o_Halted = 0, o_Fault = 0.
- The first instruction after reset begins at M1.
- Advance condition: `i_Clk_En & ~i_Stall`. When it is false, all registers hold and o_IR_Latch = 0.
- Step rotates left each advance: 0001 → 0010 → 0100 → 1000 → 0001.
- An M-cycle boundary is an advance with Step = 1000.
- `i_IR_Fetch` is sampled only at a boundary.
- RUN, at a boundary:
  - If i_IR_Fetch = 1 and i_Halt = 0: Count becomes 0x01.
  - If i_IR_Fetch = 1 and i_Halt = 1: Count becomes 0x00 and the state goes to HALT.
  - If i_IR_Fetch = 0: Count shifts left by one.
  - If i_IR_Fetch = 0 and Count = 0x80: overrun. Count becomes 0x01 and o_Fault is set.
- o_IR_Latch = 1 on the boundary advance where i_IR_Fetch = 1, i_Halt = 0 and the state is RUN. This is a registered pulse, high for the clock following that edge.
- HALT:
  - Step keeps rotating; Count stays 0x00, so no microcode is active.
  - At a boundary with i_Wake = 1: go to RUN, Count = 0x01, o_Halted = 0, and pulse o_IR_Latch.
  - i_Wake is ignored off-boundary.
- Simultaneous events:
  - i_Stall has priority over everything, including wake and fetch.
  - i_Halt is ignored unless i_IR_Fetch = 1 at the same boundary.
- o_Fault is cleared only by reset.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- One M-cycle = STEPS advances. An instruction of N M-cycles = 4N advances without stall.
- o_Cycle_Count changes on the same edge as Step 1000 → 0001.
- Stall of k enabled clocks extends the current T-state by exactly k clocks.
- HALT exit latency: wake is recognised at the next boundary, then 0–3 advances to reach it, then M1.
- Asynchronous reset mid-instruction immediately forces the reset values. First boundary after release is 4 advances later.

## Configuration
- `CYCLE_SEQ_FAULT_EN` defined:
  - Overrun detection present.
  - o_Fault behaves as above.
  - A simulation-only assertion fires on overrun.
- Not defined:
  - o_Fault is tied 0.
  - Count wraps 0x80 → 0x01 silently.
  - No fault register is synthesised.

## Structure
- The shared control-unit package holds:
  - constants STEP_T1..STEP_T4 (0001..1000), MCYCLE_M1 = 0x01, MCYCLE_NONE = 0x00
  - the state enum {SEQ_RUN, SEQ_HALT}
- One sub-module is natural: `onehot_ring`.
  - Parameterised width, with enable, load-M1 and clear controls.
  - Instantiated twice: once for Step, once for Count.
- FSM and latch-pulse logic stay in cycle_sequencer.

## Test plan
- Reset, then 12 advances with i_IR_Fetch asserted only while Count = 0x04 → Count sequence 01, 02, 04, 01. o_IR_Latch pulses exactly once, after advance 12.
- i_Stall held 5 clocks while Step = 0010 → Step stays 0010 for 5 clocks. Count unchanged, no o_IR_Latch.
- i_Halt and i_IR_Fetch at a boundary → Count = 0x00 and o_Halted = 1. i_Wake raised at Step 0100 → RUN with Count = 0x01 two advances later, with o_IR_Latch pulse.
- 32 advances with i_IR_Fetch = 0 → Count reaches 0x80, then 0x01. o_Fault = 1 with macro, 0 without.
- Reset asserted mid-M-cycle (Count = 0x04, Step = 0100) → outputs immediately 0001 / 0x01 / 0 / 0.
- i_Clk_En toggled every other clock → each T-state lasts 2 clocks. Ordering is identical to the full-rate run.
